// File: rtl/uart_tx.sv
// uart_tx -- serialising UART transmitter.
//   Sends one frame per accepted word, LSB first: start(0), DATA_WIDTH data bits,
//   optional parity bit, stop(1). Each bit is held for eff_prescale CLK cycles,
//   where eff_prescale = max(prescale, 4).
// Ports:
//   CLK         clock
//   RST         synchronous active-low reset
//   P_DATA      word to send, sampled on accept
//   DATA_VALID  request; accepted only while idle
//   PAR_EN      1 = append parity bit, sampled on accept
//   PAR_TYP     0 = even parity, 1 = odd parity, sampled on accept
//   prescale    CLK cycles per bit, sampled on accept (values < 4 act as 4)
//   TX_OUT      registered serial line, idle high
//   busy        registered, high while a frame is in progress
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRE_WIDTH  = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRE_WIDTH-1:0]  prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [PRE_WIDTH-1:0] MIN_PRE  = PRE_WIDTH'(4);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] data_sr;
  logic                  par_bit;
  logic                  par_en_q;
  logic [PRE_WIDTH-1:0]  pre_q;
  logic [PRE_WIDTH-1:0]  edge_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  bit_done;

  always_comb begin
    bit_done = (edge_cnt == (pre_q - PRE_WIDTH'(1)));
  end

  // TX_OUT is loaded with the value of the bit being entered at the same edge
  // the state changes, so the line and the state stay aligned cycle for cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      data_sr  <= '0;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
      pre_q    <= MIN_PRE;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      TX_OUT   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
          if (DATA_VALID) begin
            data_sr  <= P_DATA;
            par_bit  <= PAR_TYP ? ~^P_DATA : ^P_DATA;
            par_en_q <= PAR_EN;
            pre_q    <= (prescale < MIN_PRE) ? MIN_PRE : prescale;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            TX_OUT   <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          if (bit_done) begin
            edge_cnt <= '0;
            TX_OUT   <= data_sr[0];
            state    <= DATA;
          end else begin
            edge_cnt <= edge_cnt + PRE_WIDTH'(1);
          end
        end

        DATA: begin
          if (bit_done) begin
            edge_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              if (par_en_q) begin
                TX_OUT <= par_bit;
                state  <= PARITY;
              end else begin
                TX_OUT <= 1'b1;
                state  <= STOP;
              end
            end else begin
              // data_sr[0] is the bit on the line; [1] is the next one out.
              bit_cnt <= bit_cnt + BIT_W'(1);
              data_sr <= data_sr >> 1;
              TX_OUT  <= data_sr[1];
            end
          end else begin
            edge_cnt <= edge_cnt + PRE_WIDTH'(1);
          end
        end

        PARITY: begin
          if (bit_done) begin
            edge_cnt <= '0;
            TX_OUT   <= 1'b1;
            state    <= STOP;
          end else begin
            edge_cnt <= edge_cnt + PRE_WIDTH'(1);
          end
        end

        STOP: begin
          if (bit_done) begin
            edge_cnt <= '0;
            TX_OUT   <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            edge_cnt <= edge_cnt + PRE_WIDTH'(1);
          end
        end

        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- bench for uart_tx: directed frame table plus hand-written
// sequences for reset, ignored requests, back-to-back frames and mid-frame reset.
module tb_uart_tx;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescale;
  logic       TX_OUT;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  uart_tx #(.DATA_WIDTH(8), .PRE_WIDTH(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // frame[i] is the i-th bit on the line (frame[0] = start bit).
  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic [5:0]  pre;
    logic [10:0] frame;
    int          nbits;
    int          eff;
  } vec_t;

  vec_t vecs[7];

  task automatic check_idle(input string name);
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s: tx=%b busy=%b, required tx=1 busy=0", name, TX_OUT, busy);
    end
  endtask

  // Drive a request for one cycle; returns #1 after the accepting edge.
  task automatic send(input vec_t v, input logic hold);
    @(negedge CLK);
    P_DATA     = v.data;
    PAR_EN     = v.pe;
    PAR_TYP    = v.pt;
    prescale   = v.pre;
    DATA_VALID = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) begin
      DATA_VALID = 1'b0;
      P_DATA     = ~v.data;
      PAR_EN     = ~v.pe;
      PAR_TYP    = ~v.pt;
      prescale   = v.pre ^ 6'h2A;
    end
  endtask

  // Check every cycle of a frame whose accept edge has just passed, then the
  // first idle cycle. DATA_VALID is set to keep_dv after cycle 0; a one-cycle
  // request for 0x81 is injected after cycle inject_at (if >= 0).
  task automatic check_frame(input vec_t v, input int inject_at, input logic keep_dv,
                             input string name);
    for (int b = 0; b < v.nbits; b++) begin
      int   bad;
      logic exp_bit;
      logic seen_tx;
      logic seen_busy;
      bad       = 0;
      exp_bit   = v.frame[b];
      seen_tx   = exp_bit;
      seen_busy = 1'b1;
      for (int c = 0; c < v.eff; c++) begin
        int k;
        k = b * v.eff + c;
        @(negedge CLK);
        if (TX_OUT !== exp_bit || busy !== 1'b1) begin
          bad++;
          seen_tx   = TX_OUT;
          seen_busy = busy;
        end
        if (k == 0) DATA_VALID = keep_dv;
        if (k == inject_at) begin
          DATA_VALID = 1'b1;
          P_DATA     = 8'h81;
        end
        if (inject_at >= 0 && k == inject_at + 1) DATA_VALID = 1'b0;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL %s bit%0d: tx=%b busy=%b in %0d cycles, required tx=%b busy=1",
                 name, b, seen_tx, seen_busy, bad, exp_bit);
      end
    end
    check_idle({name, "_end"});
  endtask

  initial begin
    // data, pe, pt, pre, frame {stop, [parity], data, start}, nbits, eff
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 6'd8,  {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 8};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 6'd16, {1'b1, 1'b1, 8'h00, 1'b0}, 11, 16};
    vecs[2] = '{8'hFF, 1'b0, 1'b0, 6'd16, {1'b0, 1'b1, 8'hFF, 1'b0}, 10, 16};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 6'd2,  {1'b0, 1'b1, 8'h3C, 1'b0}, 10, 4};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 6'd5,  {1'b1, 1'b0, 8'h01, 1'b0}, 11, 5};
    vecs[5] = '{8'h07, 1'b1, 1'b0, 6'd0,  {1'b1, 1'b1, 8'h07, 1'b0}, 11, 4};
    vecs[6] = '{8'h80, 1'b0, 1'b0, 6'd63, {1'b0, 1'b1, 8'h80, 1'b0}, 10, 63};

    // Reset held with a pending request: line idle, no frame.
    RST        = 1'b0;
    DATA_VALID = 1'b1;
    P_DATA     = 8'hA5;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    prescale   = 6'd8;
    for (int i = 0; i < 3; i++) check_idle($sformatf("reset_c%0d", i));
    DATA_VALID = 1'b0;
    RST        = 1'b1;
    check_idle("post_reset");

    for (int i = 0; i < 7; i++) begin
      send(vecs[i], 1'b0);
      check_frame(vecs[i], -1, 1'b0, $sformatf("vec%0d", i));
    end

    // Request during a 0x3C frame is dropped; the frame is undisturbed.
    send(vecs[3], 1'b0);
    check_frame(vecs[3], 13, 1'b0, "ignore_busy");
    check_idle("ignore_idle1");
    check_idle("ignore_idle2");

    // DATA_VALID held high: second start bit follows exactly one idle cycle.
    send(vecs[3], 1'b1);
    check_frame(vecs[3], -1, 1'b1, "b2b_first");
    check_frame(vecs[3], -1, 1'b0, "b2b_second");
    check_idle("b2b_after");

    // Reset during data bit 3 of an 0xA5 frame (prescale 2 -> 4 cycles/bit).
    begin
      vec_t v;
      int   bad;
      v   = '{8'hA5, 1'b0, 1'b0, 6'd2, {1'b0, 1'b1, 8'hA5, 1'b0}, 10, 4};
      bad = 0;
      send(v, 1'b0);
      for (int k = 0; k < 17; k++) begin
        @(negedge CLK);
        if (TX_OUT !== v.frame[k / 4] || busy !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL pre_abort: %0d bad cycles before reset, required 0", bad);
      end
      RST = 1'b0;
      check_idle("abort_edge");
      RST = 1'b1;
      check_idle("abort_released");
      check_idle("abort_no_resume");
      v = '{8'h5A, 1'b1, 1'b1, 6'd6, {1'b1, 1'b1, 8'h5A, 1'b0}, 11, 6};
      send(v, 1'b0);
      check_frame(v, -1, 1'b0, "after_abort");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
